shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, data width of operand and result.
REQ-002 Parameter: AMTW, 4, width of shift-amount field (max amount 2^AMTW-1).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: start  input  1  request to begin an operation; sampled on rising clk edge only in IDLE.
REQ-006 Port: op  input  2  shift code: 00 pass, 01 shift left 1, 10 logical shift right 1, 11 arithmetic shift right 1 (sign bit replicated).
REQ-007 Port: amount  input  AMTW  number of single-bit shift steps to apply.
REQ-008 Port: din  input  WIDTH  operand captured at start.
REQ-009 Port: dout  output  WIDTH  accumulator register contents; final result while done=1 and thereafter until next accepted start.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE; busy and done SHALL be decoded from registered state only (no combinational path from inputs).
REQ-013 In IDLE with start=1 at edge E0, the block SHALL load acc=din, op_r=op, cnt=amount.
REQ-014 At E0, if amount==0 or op==00, next state SHALL be DONE; otherwise SHIFT.
REQ-015 In SHIFT, each rising edge SHALL apply exactly one single-bit step per op_r to acc and decrement cnt by 1.
REQ-016 In SHIFT, when cnt==1 at an edge, that edge SHALL perform the last step and move to DONE; cnt SHALL reach 0 and never wrap.
REQ-017 Latency: for amount N>0 and op!=00, the N-th step SHALL occur at edge E_N and done SHALL be high for exactly the cycle between E_N and E_N+1; for N==0 or op==00, done SHALL be high for the cycle between E0 and E1.
REQ-018 DONE SHALL unconditionally return to IDLE on the next edge; done SHALL never be high for two consecutive cycles.
REQ-019 start SHALL be ignored in SHIFT and DONE; op, amount, din SHALL be ignored except at the accepting edge.
REQ-020 Left step SHALL fill bit 0 with 0; logical right step SHALL fill bit WIDTH-1 with 0; arithmetic right step SHALL keep bit WIDTH-1.
REQ-021 Result SHALL equal the N-fold application of the single-bit step (e.g. ASR of negative operand saturates to all ones, LSL/LSR to zero for N>=WIDTH-equivalent bits shifted out).
REQ-022 dout SHALL hold its value in IDLE; a new accepted start SHALL overwrite it with din at E0.
REQ-023 Back-to-back: start held high continuously SHALL be accepted on the first edge in IDLE after each DONE, giving minimum spacing of N+2 cycles between accepts.

Reset
REQ-024 Asserting reset (low) SHALL immediately, without a clock edge, force state=IDLE, acc=0, cnt=0, op_r=00, so dout=0, busy=0, done=0.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation with no done pulse; after release, the block SHALL accept start on the first rising edge with reset high.

Verification
REQ-026 op=01, din=0x0001, amount=4, start at E0 -> busy high E0..E5, dout=0x0010 with done high only between E4 and E5.
REQ-027 op=11, din=0x8000, amount=15 -> dout=0xFFFF at done (after E15); op=10 same operand -> dout=0x0001.
REQ-028 amount=0 (op=01, din=0xA5A5) and op=00 (amount=7, din=0x1234) -> done between E0 and E1, dout equals din, no shift performed.
REQ-029 start pulsed at E2 and E3 during a 5-step operation with different din -> ignored; result and done timing unchanged from single-start run.
REQ-030 reset driven low between edges during SHIFT (cnt=3) -> dout=0, busy=0 immediately, no done pulse; start after release completes normally.
REQ-031 start held high continuously with amount=2 -> accepts at E0, E4, E8; done pulses after E2, E6, E10.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter, one single-bit step per clock.
//
// Accepts an operand, shift code and step count in IDLE, then applies one
// single-bit step per rising edge until the count is exhausted. It signals
// completion with a one-cycle done pulse.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   asynchronous reset, active low
//   start   in   begin an operation (sampled only in IDLE)
//   op      in   00 pass, 01 shl1, 10 lsr1, 11 asr1
//   amount  in   number of single-bit steps
//   din     in   operand, captured on the accepting edge
//   dout    out  accumulator (result while done, held in IDLE)
//   busy    out  state != IDLE
//   done    out  one-cycle completion pulse (state == DONE)
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMTW-1:0]  amount,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [AMTW-1:0]  r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] w_step;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  // One single-bit step of the latched shift code.
  always_comb begin
    w_step = r_acc;
    case (r_op)
      2'b01:   w_step = {r_acc[WIDTH-2:0], 1'b0};
      2'b10:   w_step = {1'b0, r_acc[WIDTH-1:1]};
      2'b11:   w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_step = r_acc;
    endcase
  end

  // Next-state logic. Zero steps or pass-through skips SHIFT entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((amount == '0) || (op == 2'b00)) w_state_nxt = S_DONE;
          else                                 w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: if (r_cnt == AMTW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_op  <= 2'b00;
    end else if (w_accept) begin
      r_acc <= din;
      r_cnt <= amount;
      r_op  <= op;
    end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
      // The count guard keeps cnt from wrapping even on a corrupted state.
      r_acc <= w_step;
      r_cnt <= r_cnt - AMTW'(1);
    end
  end

  assign dout = r_acc;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer. Inputs change and outputs
// are sampled 1 time unit after rising edges.
module tb_shift_sequencer;
  localparam int WIDTH = 16;
  localparam int AMTW  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [AMTW-1:0]  amount;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_fail = 0;

  shift_sequencer #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .amount (amount),
    .din    (din),
    .dout   (dout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation: start presented for E0 only, then n steps expected.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] d,
                        input int n, input logic [WIDTH-1:0] exp);
    int steps;
    steps = (o == 2'b00) ? 0 : n;
    start = 1'b1; op = o; din = d; amount = AMTW'(n);
    tick();                                   // E0
    start = 1'b0; op = 2'b00; din = '0; amount = '0;
    chk({tag, " busy@E0"}, busy, 1);
    chk({tag, " done@E0"}, done, (steps == 0));
    for (int k = 1; k <= steps; k++) begin
      tick();
      chk({tag, " busy"}, busy, 1);
      chk({tag, " done"}, done, (k == steps));
    end
    chk({tag, " dout"}, dout, exp);
    tick();
    chk({tag, " done clr"}, done, 0);
    chk({tag, " busy clr"}, busy, 0);
    tick();
    chk({tag, " dout hold"}, dout, exp);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; amount = '0; din = '0;
    #2;
    chk("rst dout", dout, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    @(negedge clk); reset = 1'b1;
    tick();

    run_op("lsl4",   2'b01, 16'h0001, 4,  16'h0010);
    run_op("asr15",  2'b11, 16'h8000, 15, 16'hFFFF);
    run_op("lsr15",  2'b10, 16'h8000, 15, 16'h0001);
    run_op("amt0",   2'b01, 16'hA5A5, 0,  16'hA5A5);
    run_op("pass",   2'b00, 16'h1234, 7,  16'h1234);
    run_op("asrpos", 2'b11, 16'h7F00, 3,  16'h0FE0);
    run_op("lsl15",  2'b01, 16'hFFFF, 15, 16'h8000);

    // start pulsed at E2/E3 with a different operand must be ignored.
    start = 1'b1; op = 2'b01; din = 16'h0003; amount = 4'd5;
    tick();                                   // E0
    start = 1'b0; din = 16'hFFFF; op = 2'b10; amount = 4'd1;
    tick();                                   // E1
    start = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 3) start = 1'b0;
      chk("ign done", done, (k == 5));
      chk("ign busy", busy, 1);
    end
    chk("ign dout", dout, 16'h0060);
    tick();
    chk("ign done clr", done, 0);
    tick();

    // Reset mid-shift when cnt==3.
    start = 1'b1; op = 2'b01; din = 16'h0001; amount = 4'd5;
    tick();                                   // E0
    start = 1'b0;
    tick(); tick();                           // E1, E2 -> cnt=3
    #2 reset = 1'b0;
    #1;
    chk("mid rst dout", dout, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst no done", done, 0);
    end
    @(negedge clk); reset = 1'b1;
    run_op("post rst", 2'b10, 16'hF000, 4, 16'h0F00);

    // start held: accepts at E0, E4, E8; done after E2, E6, E10.
    start = 1'b1; op = 2'b01; din = 16'h0001; amount = 4'd2;
    tick();                                   // E0
    chk("b2b busy@E0", busy, 1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk("b2b done", done, (c % 4 == 2));
      chk("b2b busy", busy, (c % 4 != 3));
      if (c % 4 == 2) chk("b2b dout", dout, 16'h0004);
    end
    start = 1'b0;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
